pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core.
- Generates the stall_i[5:0] and flush_i[3:0] vectors that every pipeline register (if_id, id_ex, ex_mem, mem_wb) and the PC unit consume.
- Arbitrates between stall requests, EX-stage jumps, synchronous exception traps and asynchronous interrupts.
- Owns the PC redirect and holds a pending interrupt until the pipeline can accept it.

Parameters:
- XLEN, 32, width of PC / redirect address
- WDT_W, 16, width of the stall watchdog counter (used only with the optional feature)
- WDT_LIMIT, 1024, consecutive-stall count that raises the watchdog timeout

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- stallreq_id_i  input  1  load-use hazard from id
- stallreq_ex_i  input  1  multi-cycle op (div/mul) busy from ex
- stallreq_mem_i  input  1  data bus wait from mem
- jump_req_i  input  1  taken branch/jump resolved in ex
- jump_addr_i  input  XLEN  jump target
- trap_req_i  input  1  synchronous exception/mret from csr; level, held until trap_ack_o
- trap_addr_i  input  XLEN  trap/mret target, valid with trap_req_i
- irq_i  input  1  one-cycle interrupt pulse from clint
- irq_addr_i  input  XLEN  interrupt vector, valid with irq_i
- stall_o  output  6  [0]pc [1]if [2]id [3]ex [4]mem [5]wb
- flush_o  output  4  [0]if_id [1]id_ex [2]ex_mem [3]mem_wb
- redirect_o  output  1  PC redirect strobe
- redirect_pc_o  output  XLEN  redirect target
- trap_ack_o  output  1  one-cycle acknowledge of trap_req_i
- irq_taken_o  output  1  one-cycle strobe when the pending interrupt is issued
- stall_timeout_o  output  1  watchdog flag (tied 0 without the optional feature)

Behaviour:
- stall_o is combinational, same cycle, priority mem > ex > id:
  - stallreq_mem_i gives 6'b011111
  - else stallreq_ex_i gives 6'b001111
  - else stallreq_id_i gives 6'b000111
  - else 6'b000000
  - wb is never stalled.
- Issue window ("can_issue"): stallreq_mem_i == 0. Traps and interrupts are issued only in the window; jumps are never blocked, because a stalled EX keeps jump_req_i asserted.
- Event priority in one cycle: trap > pending irq > jump.
  - Trap issue: flush_o = 4'b0111, redirect_o = 1, redirect_pc_o = trap_addr_i, trap_ack_o = 1.
  - Irq issue: flush_o = 4'b0111, redirect = latched vector, irq_taken_o = 1.
  - Jump: flush_o = 4'b0011, redirect = jump_addr_i; only if no trap/irq is issued that cycle, otherwise the jump is dropped.
- A flush overrides stall for the flushed stages. Whenever flush_o[1] = 1, stall_o[2:0] is also forced to 0 so the PC loads the redirect.
- Irq state machine, states IDLE and PEND:
  - IDLE: irq_i = 1 latches irq_addr_i and moves to PEND. This happens even in the cycle it could issue, so issue is always from PEND, i.e. 1 cycle after the pulse.
  - PEND: issue when can_issue and no trap_req_i, then return to IDLE.
  - irq_i while in PEND is ignored (first vector kept).
  - irq_i in the same cycle PEND issues re-latches and stays PEND.
- Trap handshake: trap_ack_o pulses exactly one cycle per request. The source drops trap_req_i the cycle after ack; a trap_req_i still high 1 cycle after ack is treated as a new request.
- Reset (asynchronous): state = IDLE, latched vector = 0, watchdog counter = 0. Combinational outputs follow the inputs. With all requests low, every output is 0.
- Reset mid-PEND discards the pending interrupt.

Optional Feature:
- Macro: PIPE_CTRL_STALL_WDT_EN.
- Defined:
  - WDT_W-bit counter increments on every cycle with stall_o[0] = 1 and clears on any cycle with stall_o[0] = 0.
  - Saturates at WDT_LIMIT.
  - stall_timeout_o is registered and is 1 while count == WDT_LIMIT.
- Undefined: no counter, stall_timeout_o = 0.

Decomposition:
- Shared defines.v additions:
  - STALL_BUS (5:0) and FLUSH_BUS (3:0) widths.
  - Named stage-bit indices.
  - Stall patterns STALL_NONE, STALL_ID, STALL_EX, STALL_MEM.
  - Flush patterns FLUSH_JUMP and FLUSH_TRAP.
- Pipeline state uses the existing dff_lrc flop primitive.
- One sub-module, pipe_stall_wdt (watchdog counter), instantiated only under the macro.

Test Plan:
- stallreq_id_i = 1 only -> stall_o = 6'b000111, flush_o = 0. Add stallreq_mem_i = 1 -> stall_o = 6'b011111.
- jump_req_i = 1, jump_addr_i = 32'h0000_0100 -> same cycle flush_o = 4'b0011, redirect_o = 1, redirect_pc_o = 32'h100, stall_o[2:0] = 0.
- trap_req_i and jump_req_i both high, trap_addr_i = 32'h8000_0000 -> flush_o = 4'b0111, redirect_pc_o = 32'h8000_0000, trap_ack_o = 1 for exactly one cycle; the jump is dropped.
- irq_i pulse (vector 32'h40) while stallreq_mem_i = 1 for 5 cycles -> no redirect during the stall; irq_taken_o and redirect_pc_o = 32'h40 in the first cycle with stallreq_mem_i = 0.
- Second irq_i (vector 32'h80) while PEND -> issued vector remains 32'h40. rst_n low during PEND -> no irq_taken_o after reset release.
- Under the macro with WDT_LIMIT = 8: hold stallreq_ex_i for 10 cycles -> stall_timeout_o rises after the 8th stalled cycle; release -> returns to 0 the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall/flush bus widths, stage indices, control patterns and irq states
package pipe_ctrl_pkg;
   localparam int STALL_W = 6;
   localparam int FLUSH_W = 4;
   localparam int STG_PC = 0, STG_IF = 1, STG_ID = 2, STG_EX = 3, STG_MEM = 4, STG_WB = 5;
   localparam int FL_IF_ID = 0, FL_ID_EX = 1, FL_EX_MEM = 2, FL_MEM_WB = 3;
   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
   localparam logic [FLUSH_W-1:0] FLUSH_NONE = 4'b0000;
   localparam logic [FLUSH_W-1:0] FLUSH_JUMP = 4'b0011;
   localparam logic [FLUSH_W-1:0] FLUSH_TRAP = 4'b0111;
   typedef enum logic {IRQ_IDLE, IRQ_PEND} irq_state_e;
   function automatic logic [STALL_W-1:0] stall_pattern(input logic id, input logic ex, input logic mem);
      return mem ? STALL_MEM : ex ? STALL_EX : id ? STALL_ID : STALL_NONE;
   endfunction
endpackage

// File: rtl/pipe_stall_wdt.sv
// pipe_stall_wdt: saturating consecutive-stall counter with a registered timeout flag
module pipe_stall_wdt #(
   parameter int WDT_W     = 16,
   parameter int WDT_LIMIT = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall_i,
   output logic timeout_o
);
   localparam logic [WDT_W-1:0] LIMIT = WDT_W'(WDT_LIMIT);
   logic [WDT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   always_comb begin
      cnt_d     = !stall_i ? '0 : (cnt_q == LIMIT) ? cnt_q : cnt_q + 1'b1;
      timeout_d = cnt_d == LIMIT;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
   assign timeout_o = timeout_q;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush/redirect arbiter with pending-interrupt holding.
// Define PIPE_CTRL_STALL_WDT_EN to add the stall watchdog (stall_timeout_o).
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int WDT_W     = 16,
   parameter int WDT_LIMIT = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stallreq_id_i,
   input  logic               stallreq_ex_i,
   input  logic               stallreq_mem_i,
   input  logic               jump_req_i,
   input  logic [XLEN-1:0]    jump_addr_i,
   input  logic               trap_req_i,
   input  logic [XLEN-1:0]    trap_addr_i,
   input  logic               irq_i,
   input  logic [XLEN-1:0]    irq_addr_i,
   output logic [STALL_W-1:0] stall_o,
   output logic [FLUSH_W-1:0] flush_o,
   output logic               redirect_o,
   output logic [XLEN-1:0]    redirect_pc_o,
   output logic               trap_ack_o,
   output logic               irq_taken_o,
   output logic               stall_timeout_o
);
   irq_state_e         state_q, state_d;
   logic [XLEN-1:0]    vec_q, vec_d;
   logic               can_issue, trap_issue, irq_issue, jump_issue, take_new;
   logic [STALL_W-1:0] stall_base;
   always_comb begin
      can_issue     = !stallreq_mem_i;
      trap_issue    = trap_req_i && can_issue;
      irq_issue     = (state_q == IRQ_PEND) && can_issue && !trap_req_i;
      jump_issue    = jump_req_i && !trap_issue && !irq_issue;
      flush_o       = (trap_issue || irq_issue) ? FLUSH_TRAP : jump_issue ? FLUSH_JUMP : FLUSH_NONE;
      stall_base    = stall_pattern(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
      // PC/IF/ID must move so the PC can load the redirect target
      stall_o       = flush_o[FL_ID_EX] ? {stall_base[STALL_W-1:STG_ID+1], 3'b000} : stall_base;
      redirect_o    = trap_issue || irq_issue || jump_issue;
      redirect_pc_o = trap_issue ? trap_addr_i : irq_issue ? vec_q : jump_issue ? jump_addr_i : '0;
      trap_ack_o    = trap_issue;
      irq_taken_o   = irq_issue;
      take_new      = irq_i && ((state_q == IRQ_IDLE) || irq_issue);
      state_d       = take_new ? IRQ_PEND : irq_issue ? IRQ_IDLE : state_q;
      vec_d         = take_new ? irq_addr_i : vec_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IRQ_IDLE;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
      end
   end
`ifdef PIPE_CTRL_STALL_WDT_EN
   pipe_stall_wdt #(.WDT_W(WDT_W), .WDT_LIMIT(WDT_LIMIT)) u_wdt (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall_i   (stall_o[STG_PC]),
      .timeout_o (stall_timeout_o)
   );
`else
   assign stall_timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus a randomized run against a queue-based reference model
module tb_pipe_ctrl;
   localparam int XLEN = 32;
   localparam int LIM  = 8;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        sid = 0, sex = 0, smem = 0, jreq = 0, treq = 0, irq = 0;
   logic [31:0] jaddr = 0, taddr = 0, iaddr = 0;
   logic [5:0]  stall;
   logic [3:0]  flush;
   logic        redir, tack, itaken, tmo;
   logic [31:0] rpc;
   logic [44:0] o;
   int          total = 0, bad = 0;

   pipe_ctrl #(.XLEN(XLEN), .WDT_W(16), .WDT_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n),
      .stallreq_id_i(sid), .stallreq_ex_i(sex), .stallreq_mem_i(smem),
      .jump_req_i(jreq), .jump_addr_i(jaddr),
      .trap_req_i(treq), .trap_addr_i(taddr),
      .irq_i(irq), .irq_addr_i(iaddr),
      .stall_o(stall), .flush_o(flush), .redirect_o(redir), .redirect_pc_o(rpc),
      .trap_ack_o(tack), .irq_taken_o(itaken), .stall_timeout_o(tmo)
   );

   always #5 clk = ~clk;
   assign o = {stall, flush, redir, rpc, tack, itaken};

   task automatic step(input logic i_id, input logic i_ex, input logic i_mem, input logic i_j,
                       input logic i_t, input logic i_irq, input logic [31:0] ja, input logic [31:0] ta,
                       input logic [31:0] ia);
      @(negedge clk);
      sid = i_id; sex = i_ex; smem = i_mem; jreq = i_j; treq = i_t; irq = i_irq;
      jaddr = ja; taddr = ta; iaddr = ia;
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      {sid, sex, smem, jreq, treq, irq} = '0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      {sid, sex, smem, jreq, treq, irq} = '0;
      #2;
      total++; if (o !== 45'd0 || tmo !== 1'b0) begin bad++; $display("FAIL reset_idle: got %h/%b want 0/0", o, tmo); end
      sid = 1'b1; #1;
      total++; if (stall !== 6'b000111) begin bad++; $display("FAIL reset_comb_stall: got %b want 000111", stall); end
      @(negedge clk);
      sid = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_stall_prio();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b000111, 39'd0}) begin bad++; $display("FAIL stall_id: got %h want %h", o, {6'b000111, 39'd0}); end
      step(1, 0, 1, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b011111, 39'd0}) begin bad++; $display("FAIL stall_mem: got %h want %h", o, {6'b011111, 39'd0}); end
      step(1, 1, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b001111, 39'd0}) begin bad++; $display("FAIL stall_ex: got %h want %h", o, {6'b001111, 39'd0}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== 45'd0) begin bad++; $display("FAIL stall_none: got %h want 0", o); end
   endtask

   task automatic test_jump();
      step(0, 0, 0, 1, 0, 0, 32'h100, 0, 0);
      total++; if (o !== {6'b000000, 4'b0011, 1'b1, 32'h100, 2'b00}) begin bad++; $display("FAIL jump: got %h want %h", o, {6'b000000, 4'b0011, 1'b1, 32'h100, 2'b00}); end
      step(1, 1, 1, 1, 0, 0, 32'h104, 0, 0);
      total++; if (o !== {6'b011000, 4'b0011, 1'b1, 32'h104, 2'b00}) begin bad++; $display("FAIL jump_mem_stall: got %h want %h", o, {6'b011000, 4'b0011, 1'b1, 32'h104, 2'b00}); end
      step(1, 0, 0, 1, 0, 0, 32'h108, 0, 0);
      total++; if (o !== {6'b000000, 4'b0011, 1'b1, 32'h108, 2'b00}) begin bad++; $display("FAIL jump_id_stall: got %h want %h", o, {6'b000000, 4'b0011, 1'b1, 32'h108, 2'b00}); end
   endtask

   task automatic test_trap();
      step(0, 0, 0, 1, 1, 0, 32'h200, 32'h8000_0000, 0);
      total++; if (o !== {6'b000000, 4'b0111, 1'b1, 32'h8000_0000, 2'b10}) begin bad++; $display("FAIL trap_over_jump: got %h want %h", o, {6'b000000, 4'b0111, 1'b1, 32'h8000_0000, 2'b10}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== 45'd0) begin bad++; $display("FAIL trap_ack_once: got %h want 0", o); end
      step(0, 0, 1, 0, 1, 0, 0, 32'h300, 0);
      total++; if (o !== {6'b011111, 39'd0}) begin bad++; $display("FAIL trap_blocked: got %h want %h", o, {6'b011111, 39'd0}); end
      step(0, 1, 0, 0, 1, 0, 0, 32'h300, 0);
      total++; if (o !== {6'b001000, 4'b0111, 1'b1, 32'h300, 2'b10}) begin bad++; $display("FAIL trap_ex_stall: got %h want %h", o, {6'b001000, 4'b0111, 1'b1, 32'h300, 2'b10}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_irq_stall();
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h40);
      total++; if (o !== {6'b011111, 39'd0}) begin bad++; $display("FAIL irq_pulse_stalled: got %h want %h", o, {6'b011111, 39'd0}); end
      for (int k = 0; k < 4; k++) begin
         step(0, 0, 1, 0, 0, 0, 0, 0, 0);
         total++; if (o !== {6'b011111, 39'd0}) begin bad++; $display("FAIL irq_held_%0d: got %h want %h", k, o, {6'b011111, 39'd0}); end
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b000000, 4'b0111, 1'b1, 32'h40, 2'b01}) begin bad++; $display("FAIL irq_issue: got %h want %h", o, {6'b000000, 4'b0111, 1'b1, 32'h40, 2'b01}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== 45'd0) begin bad++; $display("FAIL irq_once: got %h want 0", o); end
      step(0, 0, 0, 0, 0, 1, 0, 0, 32'h44);
      total++; if (o !== 45'd0) begin bad++; $display("FAIL irq_latency0: got %h want 0", o); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b000000, 4'b0111, 1'b1, 32'h44, 2'b01}) begin bad++; $display("FAIL irq_latency1: got %h want %h", o, {6'b000000, 4'b0111, 1'b1, 32'h44, 2'b01}); end
   endtask

   task automatic test_irq_pend_rules();
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h40);
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h80);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== {6'b000000, 4'b0111, 1'b1, 32'h40, 2'b01}) begin bad++; $display("FAIL irq_first_kept: got %h want %h", o, {6'b000000, 4'b0111, 1'b1, 32'h40, 2'b01}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (o !== 45'd0) begin bad++; $display("FAIL irq_second_dropped: got %h want 0", o); end
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h50);
      step(0, 0, 0, 0, 0, 1, 0, 0, 32'h60);
      total++; if (rpc !== 32'h50 || itaken !== 1'b1) begin bad++; $display("FAIL irq_relatch_a: got %h/%b want 50/1", rpc, itaken); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (rpc !== 32'h60 || itaken !== 1'b1) begin bad++; $display("FAIL irq_relatch_b: got %h/%b want 60/1", rpc, itaken); end
      step(0, 0, 0, 0, 0, 1, 0, 0, 32'h70);
      step(0, 0, 0, 0, 1, 0, 0, 32'h400, 0);
      total++; if (o !== {6'b000000, 4'b0111, 1'b1, 32'h400, 2'b10}) begin bad++; $display("FAIL trap_over_irq: got %h want %h", o, {6'b000000, 4'b0111, 1'b1, 32'h400, 2'b10}); end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (rpc !== 32'h70 || itaken !== 1'b1) begin bad++; $display("FAIL irq_after_trap: got %h/%b want 70/1", rpc, itaken); end
      step(0, 0, 1, 0, 0, 1, 0, 0, 32'h90);
      @(negedge clk);
      {sid, sex, smem, jreq, treq, irq} = '0;
      rst_n = 1'b0;
      #2;
      total++; if (o !== 45'd0) begin bad++; $display("FAIL reset_mid_pend: got %h want 0", o); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0, 0);
         total++; if (itaken !== 1'b0 || redir !== 1'b0) begin bad++; $display("FAIL irq_discarded_%0d: got %b%b want 00", k, itaken, redir); end
      end
   endtask

   task automatic test_wdt();
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         step(0, 1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_STALL_WDT_EN
         total++; if (tmo !== (k >= LIM + 1)) begin bad++; $display("FAIL wdt_cycle_%0d: got %b want %b", k, tmo, k >= LIM + 1); end
`else
         total++; if (tmo !== 1'b0) begin bad++; $display("FAIL wdt_off_%0d: got %b want 0", k, tmo); end
`endif
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_STALL_WDT_EN
      total++; if (tmo !== 1'b1) begin bad++; $display("FAIL wdt_release: got %b want 1", tmo); end
`endif
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL wdt_clear: got %b want 0", tmo); end
   endtask

   task automatic test_random();
      logic [31:0] q[$];
      int          run;
      logic        tsrc, can, ti, ii, ji;
      logic [31:0] tsrc_addr, epc;
      logic [3:0]  ef;
      logic [5:0]  es;
      logic        etmo;
      run = 0; tsrc = 0; tsrc_addr = 0;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         sid = ($urandom % 4) == 0; sex = ($urandom % 5) == 0; smem = ($urandom % 3) == 0;
         jreq = ($urandom % 4) == 0; irq = ($urandom % 6) == 0;
         jaddr = $urandom; iaddr = $urandom;
         treq = tsrc; taddr = tsrc ? tsrc_addr : $urandom;
         #2;
         can = !smem;
         ti = treq && can;
         ii = (q.size() > 0) && can && !treq;
         ji = jreq && !ti && !ii;
         ef = (ti || ii) ? 4'b0111 : ji ? 4'b0011 : 4'b0000;
         es = smem ? 6'b011111 : sex ? 6'b001111 : sid ? 6'b000111 : 6'b000000;
         if (ef[1]) es = es & 6'b111000;
         epc = ti ? taddr : ii ? q[0] : ji ? jaddr : 32'h0;
         total++;
         if (o !== {es, ef, ti || ii || ji, epc, ti, ii}) begin
            bad++; $display("FAIL rand_%0d: got %h want %h", n, o, {es, ef, ti || ii || ji, epc, ti, ii});
         end
`ifdef PIPE_CTRL_STALL_WDT_EN
         etmo = run >= LIM;
`else
         etmo = 1'b0;
`endif
         total++; if (tmo !== etmo) begin bad++; $display("FAIL rand_tmo_%0d: got %b want %b", n, tmo, etmo); end
         run = es[0] ? run + 1 : 0;
         if (ii) void'(q.pop_front());
         if (irq && q.size() == 0) q.push_back(iaddr);
         if (ti) tsrc = 1'b0;
         else if (!tsrc && ($urandom % 5) == 0) begin tsrc = 1'b1; tsrc_addr = $urandom; end
      end
   endtask

   initial begin
      test_reset();
      test_stall_prio();
      test_jump();
      test_trap();
      test_irq_stall();
      test_irq_pend_rules();
      test_wdt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
